// File: rtl/controller_pkg.sv
// Shared definitions for the gamepad reader: FSM state encoding and the
// button bit positions used by the CPU-side address decode.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        COMMIT
    } state_t;

    localparam int NUM_BTNS   = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_2ff_m.sv
// Single-bit two-flop synchronizer for the asynchronous pad data lines.
module sync_2ff_m #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic gpu_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/controller_reader_m.sv
// Once-per-frame reader for two NES-style (4021) gamepads. A rising edge on
// start_fetch latches both pads, shifts 8 active-low bits from each in
// parallel, then commits both bytes together for the CPU read bus.
module controller_reader_m #(
    parameter int LATCH_CYCLES = 302,
    parameter int HALF_PERIOD  = 151
) (
    input  logic       gpu_clk,
    input  logic       rst,
    input  logic       start_fetch,
    output logic       controller_latch,
    output logic       controller_pulse,
    input  logic       controller_data_1,
    input  logic       controller_data_2,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2,
    output logic [7:0] data_out,
    output logic       fetch_done
);

    import controller_pkg::*;

    localparam int CNT_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       N_LAST     = 3'(NUM_BTNS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       n_q, n_d;
    logic [7:0]       shadow1_q, shadow1_d;
    logic [7:0]       shadow2_q, shadow2_d;
    logic [7:0]       committed1_q;
    logic [7:0]       committed2_q;
    logic             start_prev_q;
    logic             start_edge;
    logic             latch_q;
    logic             pulse_q;
    logic             done_q;
    logic             sync_1;
    logic             sync_2;

    sync_2ff_m #(.RESET_VAL(1'b1)) u_sync_1 (
        .gpu_clk (gpu_clk),
        .rst     (rst),
        .d       (controller_data_1),
        .q       (sync_1)
    );

    sync_2ff_m #(.RESET_VAL(1'b1)) u_sync_2 (
        .gpu_clk (gpu_clk),
        .rst     (rst),
        .d       (controller_data_2),
        .q       (sync_2)
    );

    assign start_edge = start_fetch & ~start_prev_q;

    // Next-state, phase counter, bit index and shadow capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = LATCH;
                    cnt_d   = LATCH_LOAD;
                    n_d     = '0;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    shadow1_d[n_q] = ~sync_1;
                    shadow2_d[n_q] = ~sync_2;
                    if (n_q == N_LAST) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = HIGH;
                        cnt_d   = HALF_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    n_d     = n_q + 3'd1;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; pad strobes are flopped from the next state so they
    // change on the same edge as the state and are glitch-free.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            shadow1_q    <= '0;
            shadow2_q    <= '0;
            committed1_q <= '0;
            committed2_q <= '0;
            start_prev_q <= 1'b0;
            latch_q      <= 1'b0;
            pulse_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            shadow1_q    <= shadow1_d;
            shadow2_q    <= shadow2_d;
            start_prev_q <= start_fetch;
            latch_q      <= (state_d == LATCH);
            pulse_q      <= (state_d == HIGH);
            done_q       <= (state_d == COMMIT);
            if (state_q == COMMIT) begin
                committed1_q <= shadow1_q;
                committed2_q <= shadow2_q;
            end
        end
    end

    assign controller_latch = latch_q;
    assign controller_pulse = pulse_q;
    assign fetch_done       = done_q;

    // Pad 1 wins when both selects are high; bus floats when unselected.
    assign data_out = SELECT_controller_1 ? committed1_q :
                      SELECT_controller_2 ? committed2_q : 'z;

endmodule

// File: tb/tb_controller_reader_m.sv
// Bench for controller_reader_m with short timing (LATCH_CYCLES=4,
// HALF_PERIOD=3). Two serial pad models feed the DUT; a frame-level model
// predicts strobes, fetch_done and bus contents on every cycle, and
// directed fetches pin that model with hand-computed literals.
module tb_controller_reader_m;

    localparam int L      = 4;
    localparam int H      = 3;
    localparam int DONE_K = L + 15 * H + 1;  // 50

    logic       gpu_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_fetch = 1'b0;
    logic       sel1 = 1'b0;
    logic       sel2 = 1'b0;
    logic       controller_latch;
    logic       controller_pulse;
    logic       controller_data_1;
    logic       controller_data_2;
    logic       fetch_done;
    // Pulled-up bus: an undriven (z) data_out reads as all ones.
    tri1  [7:0] data_out;

    logic [7:0] pad1 = 8'h00;
    logic [7:0] pad2 = 8'h00;
    int         pidx = 0;

    int checks = 0;
    int passes = 0;

    always #5 gpu_clk = ~gpu_clk;

    controller_reader_m #(
        .LATCH_CYCLES (L),
        .HALF_PERIOD  (H)
    ) dut (
        .gpu_clk             (gpu_clk),
        .rst                 (rst),
        .start_fetch         (start_fetch),
        .controller_latch    (controller_latch),
        .controller_pulse    (controller_pulse),
        .controller_data_1   (controller_data_1),
        .controller_data_2   (controller_data_2),
        .SELECT_controller_1 (sel1),
        .SELECT_controller_2 (sel2),
        .data_out            (data_out),
        .fetch_done          (fetch_done)
    );

    // 4021 pad models: latch reloads bit 0 (A), each pulse rise advances one bit.
    always @(posedge controller_latch) pidx = 0;
    always @(posedge controller_pulse) pidx = pidx + 1;
    assign controller_data_1 = (pidx < 8) ? ~pad1[pidx[2:0]] : 1'b0;
    assign controller_data_2 = (pidx < 8) ? ~pad2[pidx[2:0]] : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Observation index k counts cycles after the accepting edge (k=1 is the first).
    function automatic logic exp_pulse(input int k);
        for (int j = 0; j < 7; j++)
            if (k >= L + H + 1 + 2 * j * H && k <= L + 2 * H + 2 * j * H) return 1'b1;
        return 1'b0;
    endfunction

    // Frame-level model plus per-cycle comparison.
    bit         m_active = 1'b0;
    bit         m_prev = 1'b0;
    int         m_k = 0;
    logic [7:0] m_b1 = 8'h00;
    logic [7:0] m_b2 = 8'h00;

    always @(posedge gpu_clk) begin
        logic [7:0] exp_bus;
        if (rst) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
            m_k      = 0;
            m_b1     = 8'h00;
            m_b2     = 8'h00;
        end else begin
            if (m_active) begin
                m_k++;
                if (m_k == DONE_K + 1) begin
                    m_b1     = pad1;
                    m_b2     = pad2;
                    m_active = 1'b0;
                end
            end else if (start_fetch && !m_prev) begin
                m_active = 1'b1;
                m_k      = 1;
            end
            m_prev = start_fetch;
        end
        #1;
        chk("mon_latch", 32'(controller_latch), 32'(m_active && m_k >= 1 && m_k <= L));
        chk("mon_pulse", 32'(controller_pulse), 32'(m_active && exp_pulse(m_k)));
        chk("mon_done",  32'(fetch_done),       32'(m_active && m_k == DONE_K));
        exp_bus = sel1 ? m_b1 : (sel2 ? m_b2 : 8'hFF);
        chk("mon_bus",   32'(data_out),         32'(exp_bus));
    end

    // mode 0: short strobe; 1: long strobe with re-trigger at k=20; 2: selects toggle.
    task automatic do_fetch(input int mode, output int lat_n, output int rises,
                            output int hi_n, output int done_n, output int done_k,
                            output logic [7:0] d50, output logic [7:0] d51);
        logic prev_pulse;
        prev_pulse = 1'b0;
        lat_n = 0; rises = 0; hi_n = 0; done_n = 0; done_k = -1;
        d50 = 8'h00; d51 = 8'h00;
        @(negedge gpu_clk);
        start_fetch = 1'b1;
        sel1 = 1'b1;
        sel2 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge gpu_clk);
            if (controller_latch) lat_n++;
            if (controller_pulse) hi_n++;
            if (controller_pulse && !prev_pulse) rises++;
            prev_pulse = controller_pulse;
            if (fetch_done) begin done_n++; done_k = k; end
            if (k == 50) d50 = data_out;
            if (k == 51) d51 = data_out;
            case (mode)
                1:       start_fetch = (k <= 31) && !(k == 18 || k == 19);
                default: start_fetch = (k < 3);
            endcase
            if (mode == 2) begin
                sel1 = (k % 2) == 1;
                sel2 = ((k / 2) % 2) == 1;
            end
        end
        start_fetch = 1'b0;
        sel1 = 1'b0;
        sel2 = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic s1, input logic s2, input logic [7:0] exp);
        @(negedge gpu_clk);
        sel1 = s1;
        sel2 = s2;
        #1;
        chk(name, 32'(data_out), 32'(exp));
    endtask

    initial begin
        int lat_n, rises, hi_n, done_n, done_k;
        logic [7:0] d50, d51;

        // Reset
        repeat (2) @(negedge gpu_clk);
        rst = 1'b0;
        chk("rst_latch", 32'(controller_latch), 32'd0);
        chk("rst_pulse", 32'(controller_pulse), 32'd0);
        chk("rst_done",  32'(fetch_done),       32'd0);
        read_chk("rst_none", 1'b0, 1'b0, 8'hFF);
        read_chk("rst_b1",   1'b1, 1'b0, 8'h00);
        read_chk("rst_b2",   1'b0, 1'b1, 8'h00);

        // Full fetch
        pad1 = 8'h5A; pad2 = 8'hC3;
        do_fetch(0, lat_n, rises, hi_n, done_n, done_k, d50, d51);
        chk("f1_latch_cycles", 32'(lat_n),  32'd4);
        chk("f1_pulse_rises",  32'(rises),  32'd7);
        chk("f1_pulse_cycles", 32'(hi_n),   32'd21);
        chk("f1_done_count",   32'(done_n), 32'd1);
        chk("f1_done_at",      32'(done_k), 32'd50);
        chk("f1_bus_t50",      32'(d50),    32'h00);
        chk("f1_bus_t51",      32'(d51),    32'h5A);
        read_chk("f1_b1", 1'b1, 1'b0, 8'h5A);
        read_chk("f1_b2", 1'b0, 1'b1, 8'hC3);

        // Long strobe with a re-trigger mid-fetch
        pad1 = 8'h11; pad2 = 8'h22;
        do_fetch(1, lat_n, rises, hi_n, done_n, done_k, d50, d51);
        chk("f2_done_count",   32'(done_n), 32'd1);
        chk("f2_latch_cycles", 32'(lat_n),  32'd4);
        chk("f2_pulse_rises",  32'(rises),  32'd7);
        read_chk("f2_b1", 1'b1, 1'b0, 8'h11);
        read_chk("f2_b2", 1'b0, 1'b1, 8'h22);

        // Atomic commit
        pad1 = 8'hFF; pad2 = 8'h00;
        do_fetch(0, lat_n, rises, hi_n, done_n, done_k, d50, d51);
        chk("f3_bus_t50", 32'(d50),    32'h11);
        chk("f3_bus_t51", 32'(d51),    32'hFF);
        chk("f3_done_at", 32'(done_k), 32'd50);
        read_chk("f3_b1", 1'b1, 1'b0, 8'hFF);
        read_chk("f3_b2", 1'b0, 1'b1, 8'h00);

        // Selects toggling throughout a fetch
        pad1 = 8'h3C; pad2 = 8'h81;
        do_fetch(2, lat_n, rises, hi_n, done_n, done_k, d50, d51);
        chk("f4_done_count",   32'(done_n), 32'd1);
        chk("f4_done_at",      32'(done_k), 32'd50);
        chk("f4_pulse_cycles", 32'(hi_n),   32'd21);
        read_chk("f4_b1",   1'b1, 1'b0, 8'h3C);
        read_chk("f4_b2",   1'b0, 1'b1, 8'h81);
        read_chk("f4_both", 1'b1, 1'b1, 8'h3C);
        read_chk("f4_none", 1'b0, 1'b0, 8'hFF);

        // Reset during the third pulse-high phase
        pad1 = 8'hA5; pad2 = 8'h96;
        @(negedge gpu_clk);
        start_fetch = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge gpu_clk);
            start_fetch = (k < 3);
        end
        chk("mr_pulse_before", 32'(controller_pulse), 32'd1);
        rst = 1'b1;
        @(negedge gpu_clk);
        chk("mr_latch", 32'(controller_latch), 32'd0);
        chk("mr_pulse", 32'(controller_pulse), 32'd0);
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge gpu_clk);
            if (fetch_done) done_n++;
        end
        chk("mr_no_done", 32'(done_n), 32'd0);
        read_chk("mr_b1", 1'b1, 1'b0, 8'h00);
        read_chk("mr_b2", 1'b0, 1'b1, 8'h00);

        // Next edge fetches normally
        do_fetch(0, lat_n, rises, hi_n, done_n, done_k, d50, d51);
        chk("f5_done_count", 32'(done_n), 32'd1);
        chk("f5_bus_t51",    32'(d51),    32'hA5);
        read_chk("f5_b1", 1'b1, 1'b0, 8'hA5);
        read_chk("f5_b2", 1'b0, 1'b1, 8'h96);

        repeat (2) @(negedge gpu_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
